// File: rtl/riscv_pkg.sv
// ============================================================================
// Module  : riscv_pkg
// Brief   : Shared fetch-stage types and constants (FSM states, NOP, XLEN).
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        HALT  = 2'd3
    } ifu_state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module  : instr_fetch_unit_if
// Brief   : Instruction-memory req/ready handshake between fetch unit and memory.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface instr_fetch_unit_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    logic            IMemReq;
    logic [XLEN-1:0] IMemAddr;
    logic            IMemReady;
    logic [31:0]     IMemRdata;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemReady,
        input  IMemRdata
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemReady,
        output IMemRdata
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : PC owner and sequential fetch FSM (BOOT/FETCH/VALID[/HALT]).
//           Optional misaligned-target trap: define IFU_MISALIGN_TRAP_EN.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int               XLEN     = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    instr_fetch_unit_if.master      imem,
    input  wire logic               PCSrc,
    input  wire logic [XLEN-1:0]    PCTarget,
    input  wire logic               Stall,
    output logic [31:0]             Instr,
    output logic                    InstrValid,
    output logic [XLEN-1:0]         PC,
    output logic [XLEN-1:0]         PCPlus4,
`ifdef IFU_MISALIGN_TRAP_EN
    output logic                    InstrMisaligned,
`endif
    output logic [31:0]             RetireCount
);

    localparam logic [XLEN-1:0] c_FOUR       = XLEN'(4);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(3);

    ifu_state_t        r_state;
    logic              r_req;
    logic [XLEN-1:0]   r_addr;
    logic [31:0]       r_instr;
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_cnt;
`ifdef IFU_MISALIGN_TRAP_EN
    logic              r_misalign;
    logic              w_trap;
`endif

    logic [XLEN-1:0]   w_pc_plus4;
    logic [XLEN-1:0]   w_next_pc;

    assign w_pc_plus4 = r_pc + c_FOUR;

`ifdef IFU_MISALIGN_TRAP_EN
    assign w_trap    = PCSrc && (PCTarget[1:0] != 2'b00);
    assign w_next_pc = PCSrc ? PCTarget : w_pc_plus4;
`else
    // Low target bits are dropped so the PC can never become misaligned.
    assign w_next_pc = PCSrc ? (PCTarget & c_ALIGN_MASK) : w_pc_plus4;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
            r_pc       <= RESET_PC;
            r_cnt      <= '0;
`ifdef IFU_MISALIGN_TRAP_EN
            r_misalign <= 1'b0;
`endif
        end else begin
            case (r_state)
                BOOT: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                end
                FETCH: begin
                    if (imem.IMemReady) begin
                        r_state <= VALID;
                        r_req   <= 1'b0;
                        r_instr <= imem.IMemRdata;
                        r_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (!Stall) begin
                        r_pc    <= w_next_pc;
                        r_cnt   <= r_cnt + 32'd1;
                        r_instr <= NOP_INSTR;
                        r_valid <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
                        if (w_trap) begin
                            r_state    <= HALT;
                            r_misalign <= 1'b1;
                        end else begin
                            r_state <= FETCH;
                            r_req   <= 1'b1;
                            r_addr  <= w_next_pc;
                        end
`else
                        r_state <= FETCH;
                        r_req   <= 1'b1;
                        r_addr  <= w_next_pc;
`endif
                    end
                end
`ifdef IFU_MISALIGN_TRAP_EN
                HALT: begin
                    r_state <= HALT;
                    r_req   <= 1'b0;
                end
`endif
                default: begin
                    r_state <= BOOT;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_instr <= NOP_INSTR;
                end
            endcase
        end
    end

    assign imem.IMemReq  = r_req;
    assign imem.IMemAddr = r_addr;
    assign Instr         = r_instr;
    assign InstrValid    = r_valid;
    assign PC            = r_pc;
    assign PCPlus4       = w_pc_plus4;
    assign RetireCount   = r_cnt;
`ifdef IFU_MISALIGN_TRAP_EN
    assign InstrMisaligned = r_misalign;
`endif

endmodule

`default_nettype wire
